k12a_mem_ctrl: RTL and testbench

//  Memory-access sequencer between the K12A internal buses and the external SRAM/peripheral bus.

---
 rtl/k12a_mem_ctrl.sv | 145 ++++++++++++++
 tb/tb_k12a_mem_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k12a_mem_ctrl.sv
// k12a_mem_ctrl: sequences one external SRAM/peripheral access
// (setup, strobe with wait states and ext_ready stretch, hold).
//
// Ports:
//   cpu_clock, reset_n   clock, synchronous active-low reset
//   mem_req, mem_we      start request and direction (IDLE only)
//   mem_load             drive the read-data register onto data_bus
//   addr_bus             internal address bus (sampled only)
//   data_bus             write data in, read data out under mem_load
//   mem_busy             high in every state except IDLE
//   mem_done, mem_err    HOLD pulse; err marks a timeout abort
//   ext_addr, ext_wdata  latched external address / write data
//   ext_rdata, ext_ready external read data and wait request
//   ext_ce_n/oe_n/we_n   active-low external strobes (registered)
module k12a_mem_ctrl #(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned TIMEOUT     = 64
) (
   input  logic        cpu_clock,
   input  logic        reset_n,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic        mem_load,
   inout  wire  [15:0] addr_bus,
   inout  wire  [7:0]  data_bus,
   output logic        mem_busy,
   output logic        mem_done,
   output logic        mem_err,
   output logic [15:0] ext_addr,
   output logic [7:0]  ext_wdata,
   input  logic [7:0]  ext_rdata,
   input  logic        ext_ready,
   output logic        ext_ce_n,
   output logic        ext_oe_n,
   output logic        ext_we_n
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_STROBE = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   localparam logic [3:0] WS_INIT = WAIT_STATES[3:0];
   localparam logic [7:0] TO_INIT = TIMEOUT[7:0];
   localparam logic       HAS_TO  = (TIMEOUT != 0);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [3:0] wait_cnt;
   logic [7:0] to_cnt;
   logic [7:0] rdata;
   logic       we_q;
   logic       fin;
   logic       abort;

   // fin marks the last strobe cycle, where ext_ready matters
   always_comb begin
      state_nxt = state;
      fin       = 1'b0;
      abort     = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_req)
               state_nxt = S_SETUP;
         end
         S_SETUP: begin
            state_nxt = S_STROBE;
         end
         S_STROBE: begin
            if (wait_cnt == 4'd0) begin
               fin = 1'b1;
               if (ext_ready) begin
                  state_nxt = S_HOLD;
               end else if (HAS_TO &&
                            to_cnt == 8'd1) begin
                  abort     = 1'b1;
                  state_nxt = S_HOLD;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // strobes are decoded from the next state so
   // they change on the same edge as the state
   always_ff @(posedge cpu_clock) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         wait_cnt  <= 4'd0;
         to_cnt    <= 8'd0;
         rdata     <= 8'h00;
         we_q      <= 1'b0;
         ext_addr  <= 16'h0000;
         ext_wdata <= 8'h00;
         mem_busy  <= 1'b0;
         mem_done  <= 1'b0;
         mem_err   <= 1'b0;
         ext_ce_n  <= 1'b1;
         ext_oe_n  <= 1'b1;
         ext_we_n  <= 1'b1;
      end else begin
         state    <= state_nxt;
         mem_busy <= (state_nxt != S_IDLE);
         mem_done <= (state_nxt == S_HOLD);
         mem_err  <= abort;
         ext_ce_n <= (state_nxt == S_IDLE);
         ext_oe_n <= !(state_nxt == S_STROBE
                       && !we_q);
         ext_we_n <= !(state_nxt == S_STROBE
                       && we_q);

         if (state == S_IDLE && mem_req) begin
            ext_addr <= addr_bus;
            we_q     <= mem_we;
            if (mem_we)
               ext_wdata <= data_bus;
         end

         if (state == S_SETUP) begin
            wait_cnt <= WS_INIT;
            to_cnt   <= TO_INIT;
         end

         if (state == S_STROBE && !fin)
            wait_cnt <= wait_cnt - 4'd1;

         if (fin && !ext_ready && !abort && HAS_TO)
            to_cnt <= to_cnt - 8'd1;

         // an aborted read returns all-ones
         if (fin && !we_q) begin
            if (ext_ready)
               rdata <= ext_rdata;
            else if (abort)
               rdata <= 8'hFF;
         end
      end
   end

   assign data_bus = mem_load ? rdata : 8'hzz;

endmodule

// File: tb/tb_k12a_mem_ctrl.sv
// Bench for k12a_mem_ctrl: two instances (long and short
// timeout), directed accesses, queued expectations.
module tb_k12a_mem_ctrl;

   localparam int WS   = 1;
   localparam int TO_B = 4;

   typedef struct {
      logic        err;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
      int          oe;
      int          we;
      int          busy;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  req = 2'b00;
   logic        mem_we = 1'b0;
   logic        wdrv = 1'b0;
   logic [7:0]  wdat = 8'h00;
   logic [15:0] tb_addr = 16'h0000;
   logic [7:0]  ext_rdata = 8'h00;
   logic        ext_ready = 1'b1;
   logic        ld;

   wire  [15:0] abus;
   wire  [7:0]  dbus_a;
   wire  [7:0]  dbus_b;
   wire  [1:0]  busy, done, err;
   wire  [1:0]  ce_n, oe_n, we_n;
   wire  [15:0] xaddr_a, xaddr_b;
   wire  [7:0]  xwd_a, xwd_b;

   assign ld     = ~wdrv;
   assign abus   = tb_addr;
   assign dbus_a = wdrv ? wdat : 8'hzz;
   assign dbus_b = wdrv ? wdat : 8'hzz;

   k12a_mem_ctrl #(.WAIT_STATES(WS), .TIMEOUT(64)) u_a (
      .cpu_clock(clk), .reset_n(reset_n),
      .mem_req(req[0]), .mem_we(mem_we),
      .mem_load(ld), .addr_bus(abus),
      .data_bus(dbus_a), .mem_busy(busy[0]),
      .mem_done(done[0]), .mem_err(err[0]),
      .ext_addr(xaddr_a), .ext_wdata(xwd_a),
      .ext_rdata(ext_rdata), .ext_ready(ext_ready),
      .ext_ce_n(ce_n[0]), .ext_oe_n(oe_n[0]),
      .ext_we_n(we_n[0])
   );

   k12a_mem_ctrl #(.WAIT_STATES(WS), .TIMEOUT(TO_B)) u_b (
      .cpu_clock(clk), .reset_n(reset_n),
      .mem_req(req[1]), .mem_we(mem_we),
      .mem_load(ld), .addr_bus(abus),
      .data_bus(dbus_b), .mem_busy(busy[1]),
      .mem_done(done[1]), .mem_err(err[1]),
      .ext_addr(xaddr_b), .ext_wdata(xwd_b),
      .ext_rdata(ext_rdata), .ext_ready(ext_ready),
      .ext_ce_n(ce_n[1]), .ext_oe_n(oe_n[1]),
      .ext_we_n(we_n[1])
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_fail = 0;
   exp_t qa[$];
   exp_t qb[$];
   logic [7:0] m_rd [2];
   logic [7:0] m_wd [2];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   task automatic check_item(input string u,
                             input exp_t e,
                             input logic er,
                             input logic [15:0] ad,
                             input logic [7:0] wd,
                             input logic [7:0] db,
                             input int oc,
                             input int wc,
                             input int bc);
      chk({u, "_err"},   er, e.err);
      chk({u, "_addr"},  ad, e.addr);
      chk({u, "_wdata"}, wd, e.wdata);
      chk({u, "_rdata"}, db, e.rdata);
      chk({u, "_oe_cyc"}, oc, e.oe);
      chk({u, "_we_cyc"}, wc, e.we);
      chk({u, "_busy_cyc"}, bc, e.busy);
   endtask

   int oc_a = 0, wc_a = 0, bc_a = 0;
   int oc_b = 0, wc_b = 0, bc_b = 0;

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (!reset_n) begin
         oc_a = 0; wc_a = 0; bc_a = 0;
      end else begin
         if (!oe_n[0]) oc_a++;
         if (!we_n[0]) wc_a++;
         if (busy[0])  bc_a++;
         if (done[0]) begin
            if (qa.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL a_done: got 1 expected 0");
            end else begin
               e = qa.pop_front();
               check_item("a", e, err[0], xaddr_a,
                          xwd_a, dbus_a,
                          oc_a, wc_a, bc_a);
            end
            oc_a = 0; wc_a = 0; bc_a = 0;
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (!reset_n) begin
         oc_b = 0; wc_b = 0; bc_b = 0;
      end else begin
         if (!oe_n[1]) oc_b++;
         if (!we_n[1]) wc_b++;
         if (busy[1])  bc_b++;
         if (done[1]) begin
            if (qb.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL b_done: got 1 expected 0");
            end else begin
               e = qb.pop_front();
               check_item("b", e, err[1], xaddr_b,
                          xwd_b, dbus_b,
                          oc_b, wc_b, bc_b);
            end
            oc_b = 0; wc_b = 0; bc_b = 0;
         end
      end
   end

   task automatic wait_idle(input int u);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy[u]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_wait", ok, 1);
   endtask

   // n = ready-low cycles at strobe end; n < 0 = stuck low
   task automatic run(input int u,
                      input bit w,
                      input logic [15:0] a,
                      input logic [7:0] d,
                      input logic [7:0] rd,
                      input int n,
                      input bit poke);
      exp_t e;
      int   sl;
      bit   ab;
      ab = (n < 0);
      sl = ab ? WS + TO_B : WS + 1 + n;
      e.err   = ab;
      e.addr  = a;
      e.wdata = w ? d : m_wd[u];
      e.rdata = w ? m_rd[u] : (ab ? 8'hFF : rd);
      e.oe    = w ? 0 : sl;
      e.we    = w ? sl : 0;
      e.busy  = sl + 2;
      m_wd[u] = e.wdata;
      m_rd[u] = e.rdata;
      if (u == 0) qa.push_back(e);
      else        qb.push_back(e);
      @(negedge clk);
      req[u] = 1'b1; mem_we = w; tb_addr = a;
      wdrv = w; wdat = d; ext_rdata = rd;
      ext_ready = (n == 0);
      @(negedge clk);
      req[u] = 1'b0; wdrv = 1'b0;
      mem_we = ~w; tb_addr = ~a;
      if (poke) begin
         @(negedge clk); req[u] = 1'b1;
         @(negedge clk); req[u] = 1'b0;
      end
      if (n > 0) begin
         repeat (1 + WS + n) @(negedge clk);
         ext_ready = 1'b1;
      end
      wait_idle(u);
      ext_ready = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      exp_t e;
      bit   ok;
      m_rd[0] = 8'h00; m_rd[1] = 8'h00;
      m_wd[0] = 8'h00; m_wd[1] = 8'h00;

      repeat (3) @(negedge clk);
      chk("rst_ce_n", ce_n, 2'b11);
      chk("rst_oe_n", oe_n, 2'b11);
      chk("rst_we_n", we_n, 2'b11);
      chk("rst_busy", busy, 2'b00);
      chk("rst_done", done, 2'b00);
      chk("rst_dbus", dbus_a, 8'h00);
      chk("rst_addr", xaddr_a, 16'h0000);
      reset_n = 1'b1;

      run(0, 1'b0, 16'h1234, 8'h00, 8'hA5, 0, 1'b0);
      chk("t1_dbus", dbus_a, 8'hA5);

      run(0, 1'b1, 16'hFFFF, 8'h3C, 8'h00, 0, 1'b0);
      chk("t2_dbus", dbus_a, 8'hA5);
      chk("t2_wdata", xwd_a, 8'h3C);

      run(0, 1'b0, 16'h00F0, 8'h00, 8'h77, 5, 1'b0);

      run(1, 1'b0, 16'hBEEF, 8'h00, 8'h12, -1, 1'b0);
      @(negedge clk);
      chk("t4_dbus", dbus_b, 8'hFF);

      e.err = 1'b0; e.addr = 16'h0040;
      e.wdata = m_wd[0]; e.rdata = 8'h5A;
      e.oe = WS + 1; e.we = 0; e.busy = WS + 3;
      m_rd[0] = 8'h5A;
      qa.push_back(e);
      qa.push_back(e);
      @(negedge clk);
      req[0] = 1'b1; mem_we = 1'b0;
      tb_addr = 16'h0040; ext_rdata = 8'h5A;
      ext_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done[0]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("b2b_done1", ok, 1);
      @(negedge clk);
      chk("b2b_idle_busy", busy[0], 1'b0);
      chk("b2b_idle_ce", ce_n[0], 1'b1);
      @(negedge clk);
      chk("b2b_setup_busy", busy[0], 1'b1);
      chk("b2b_setup_ce", ce_n[0], 1'b0);
      chk("b2b_setup_oe", oe_n[0], 1'b1);
      req[0] = 1'b0;
      wait_idle(0);

      run(0, 1'b0, 16'h0A0A, 8'h00, 8'hC3, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("noqueue_busy", busy[0], 1'b0);
      end

      @(negedge clk);
      req[0] = 1'b1; mem_we = 1'b0;
      tb_addr = 16'h2222; ext_rdata = 8'h99;
      ext_ready = 1'b1;
      @(negedge clk);
      req[0] = 1'b0;
      @(negedge clk);
      chk("t5_strobe_oe", oe_n[0], 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      chk("t5_ce_n", ce_n[0], 1'b1);
      chk("t5_oe_n", oe_n[0], 1'b1);
      chk("t5_we_n", we_n[0], 1'b1);
      chk("t5_busy", busy[0], 1'b0);
      chk("t5_done", done[0], 1'b0);
      chk("t5_dbus", dbus_a, 8'h00);
      chk("t5_addr", xaddr_a, 16'h0000);
      @(negedge clk);
      chk("t5_done2", done[0], 1'b0);
      reset_n = 1'b1;
      m_rd[0] = 8'h00; m_rd[1] = 8'h00;
      m_wd[0] = 8'h00; m_wd[1] = 8'h00;

      run(0, 1'b0, 16'h5555, 8'h00, 8'h66, 0, 1'b0);

      repeat (5) @(negedge clk);
      chk("qa_empty", qa.size(), 0);
      chk("qb_empty", qb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
